// File: rtl/br_jmp_predictor_pkg.sv
// Shared types for the branch/jump predictor: RV opcodes, 2-bit counter, BTB entry.
// No logic, no latency, no backpressure.
package br_jmp_predictor_pkg;

    localparam logic [6:0] B_TYPE   = 7'b1100011;
    localparam logic [6:0] JAL_INS  = 7'b1101111;
    localparam logic [6:0] JALR_INS = 7'b1100111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    // Tag and target widths follow XLEN/ENTRIES, so they sit in parallel arrays in the top.
    typedef struct packed {
        logic valid;
        logic is_jmp;
        cnt_t cnt;
    } btb_entry_t;

    function automatic cnt_t cnt_step(cnt_t c, logic up);
        cnt_t r;
        r = c;
        if (up && (c != ST)) begin
            r = cnt_t'(2'(c) + 2'd1);
        end else if (!up && (c != SNT)) begin
            r = cnt_t'(2'(c) - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/br_jmp_predictor_if.sv
// Fetch lookup, decode target and resolve-update signals of the predictor.
// Pure wiring; no latency, no backpressure.
interface br_jmp_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic [XLEN-1:0] d_pc;
    logic [6:0]      d_opcode;
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] d_rs1;
    logic [XLEN-1:0] d_addr;
    logic            d_branch;
    logic            d_jmp;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_is_jmp;

    modport master (
        output f_pc, d_pc, d_opcode, d_imm, d_rs1,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_is_jmp,
        input  pred_hit, pred_taken, pred_target, d_addr, d_branch, d_jmp
    );

    modport slave (
        input  f_pc, d_pc, d_opcode, d_imm, d_rs1,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_jmp,
        output pred_hit, pred_taken, pred_target, d_addr, d_branch, d_jmp
    );
endinterface

// File: rtl/br_target_calc.sv
// Decode-stage branch/jump target calculation for B-type, JAL and JALR.
// Combinational, no backpressure.
module br_target_calc
    import br_jmp_predictor_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] d_pc_i,
    input  logic [6:0]      d_opcode_i,
    input  logic [XLEN-1:0] d_imm_i,
    input  logic [XLEN-1:0] d_rs1_i,
    output logic [XLEN-1:0] d_addr_o,
    output logic            d_branch_o,
    output logic            d_jmp_o
);

    localparam logic [XLEN-1:0] LSB_CLR = {{(XLEN-1){1'b1}}, 1'b0};

    always_comb begin
        d_addr_o   = '0;
        d_branch_o = 1'b0;
        d_jmp_o    = 1'b0;
        case (d_opcode_i)
            B_TYPE: begin
                d_addr_o   = d_pc_i + d_imm_i;
                d_branch_o = 1'b1;
            end
            JAL_INS: begin
                d_addr_o = d_pc_i + d_imm_i;
                d_jmp_o  = 1'b1;
            end
            JALR_INS: begin
                d_addr_o = (d_rs1_i + d_imm_i) & LSB_CLR;
                d_jmp_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/br_jmp_predictor.sv
// Direct-mapped BTB with 2-bit counters plus decode-stage target calculation.
// Lookup combinational; updates visible one cycle later; no backpressure.
module br_jmp_predictor
    import br_jmp_predictor_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input logic              clk,
    input logic              rst,
    br_jmp_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t        ent_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q [ENTRIES];
    logic [XLEN-1:0]   tgt_q [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic [IDX_W-1:0]  u_idx;
    logic [TAG_W-1:0]  u_tag;
    logic              u_hit;
    logic              ent_we;
    logic              dat_we;
    btb_entry_t        ent_d;
    logic              unused_upd_lsb;

    assign f_idx          = bp.f_pc[IDX_W+1:2];
    assign f_tag          = bp.f_pc[XLEN-1:IDX_W+2];
    assign u_idx          = bp.upd_pc[IDX_W+1:2];
    assign u_tag          = bp.upd_pc[XLEN-1:IDX_W+2];
    assign unused_upd_lsb = ^bp.upd_pc[1:0];

    always_comb begin
        bp.pred_hit    = ent_q[f_idx].valid && (tag_q[f_idx] == f_tag);
        bp.pred_taken  = bp.pred_hit && (ent_q[f_idx].cnt[1] || ent_q[f_idx].is_jmp);
        bp.pred_target = bp.pred_taken ? tgt_q[f_idx] : bp.f_pc + XLEN'(4);
    end

    always_comb begin
        u_hit  = ent_q[u_idx].valid && (tag_q[u_idx] == u_tag);
        ent_d  = ent_q[u_idx];
        ent_we = 1'b0;
        dat_we = 1'b0;
        if (bp.upd_valid) begin
            if (u_hit) begin
                ent_we    = 1'b1;
                dat_we    = bp.upd_taken;
                ent_d.cnt = bp.upd_is_jmp ? ST : cnt_step(ent_q[u_idx].cnt, bp.upd_taken);
            end else if (bp.upd_taken) begin
                // Allocation replaces whatever lived at this index.
                ent_we       = 1'b1;
                dat_we       = 1'b1;
                ent_d.valid  = 1'b1;
                ent_d.is_jmp = bp.upd_is_jmp;
                ent_d.cnt    = bp.upd_is_jmp ? ST : WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '{valid: 1'b0, is_jmp: 1'b0, cnt: cnt_t'(CNT_INIT)};
            end
        end else if (ent_we) begin
            ent_q[u_idx] <= ent_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && dat_we) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= bp.upd_target;
        end
    end

    br_target_calc #(
        .XLEN(XLEN)
    ) u_target_calc (
        .d_pc_i     (bp.d_pc),
        .d_opcode_i (bp.d_opcode),
        .d_imm_i    (bp.d_imm),
        .d_rs1_i    (bp.d_rs1),
        .d_addr_o   (bp.d_addr),
        .d_branch_o (bp.d_branch),
        .d_jmp_o    (bp.d_jmp)
    );

endmodule
